dii_packet_arbiter: RTL
=======================

# dii_packet_arbiter

Packet-atomic round-robin arbiter that merges PORTS upstream DII channels into one downstream DII channel. It sits between several debug modules, or module clusters, and a single debug-ring injection port, so that many sources can share one ring slot. A packet (first…last) is never interleaved with another. Signals are flattened vectors rather than interface arrays, so the block drops directly into generate loops around the ring.

## Interface
- PORTS, 2: number of upstream channels; legal range 2..16.
- WIDTH, 16: flit data width.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  PORTS*WIDTH  flit data; port i occupies bits [i*WIDTH +: WIDTH].
- in_first  in  PORTS  first-flit marker per port.
- in_last  in  PORTS  last-flit marker per port.
- in_valid  in  PORTS  flit valid per port.
- in_ready  out  PORTS  flit accepted per port.
- out_data  out  WIDTH  granted port's flit.
- out_first  out  1  granted port's first.
- out_last  out  1  granted port's last.
- out_valid  out  1  granted port's valid.
- out_ready  in  1  downstream ready.
- pkt_count  out  PORTS*16  per-port completed-packet counters; present only with DII_ARB_STATS_EN.

## Operation
- Transfer on a channel means valid && ready in the same cycle.
- State register has two states, IDLE and BUSY, plus grant[log2(PORTS)] and ptr[log2(PORTS)].
- IDLE:
  - out_valid=0, in_ready=0, out_data/first/last=0.
  - A request is in_valid[i]=1; in_first is not checked.
  - If any port requests, the winner is the first requesting port in order ptr+1, ptr+2, … (mod PORTS).
  - Next cycle: grant=winner, ptr=winner, state=BUSY.
  - With no request, the block stays in IDLE.
- BUSY:
  - out_* = in_*[grant], combinationally.
  - in_ready[grant]=out_ready; every other in_ready=0.
  - A transfer with in_last[grant]=1 returns the block to IDLE next cycle.
  - Any other transfer, or a stall, keeps the block in BUSY.
- The grant is held for the whole packet, including cycles where in_valid[grant]=0 mid-packet. No timeout.
- A single-flit packet (first=last=1) occupies one BUSY cycle, provided out_ready=1.
- Requests on non-granted ports during BUSY are ignored. They are held by their sources, which is the DII rule: valid may not drop without a transfer.
- rst asserted in any state, including mid-packet: the next cycle has state=IDLE, ptr=PORTS-1, grant=0 and all outputs 0. Any partial packet is abandoned. Upstream and downstream are reset by the same rst.

## Timing
- Arbitration latency: a request in IDLE at cycle n gives out_valid at cycle n+1 at the earliest.
- A packet of L flits with out_ready held high occupies L BUSY cycles, followed by 1 IDLE cycle. Throughput is therefore L/(L+1).
- The datapath has zero register stages. There is a combinational path from in_* to out_* and from out_ready to in_ready.
- Reset values:
  - out_valid=0, out_first=0, out_last=0, out_data=0.
  - in_ready=0.
  - pkt_count=0.
- Fairness: after a grant to port g, g has the lowest priority in the next arbitration. With all ports continuously requesting, grants cycle 0,1,…,PORTS-1,0,…
- ptr wrap-around: when ptr=PORTS-1, the search starts at port 0.

## Configuration
- DII_ARB_STATS_EN defined:
  - One 16-bit counter per port. It increments on each transfer with in_last[grant]=1 from that port.
  - It wraps from 16'hffff to 0 and is cleared by rst.
  - pkt_count port is present.
- DII_ARB_STATS_EN undefined: no counters and no pkt_count port. Arbitration behaviour is identical.

## Test plan
- Reset, then single request:
  - Stimulus: rst for 2 cycles; port 1 presents a 3-flit packet 16'h0001/0002/0003 with out_ready=1.
  - Response: all outputs 0 during reset; out_valid rises one cycle after in_valid; three flits appear in order with first on flit 1 and last on flit 3; out_valid=0 in the following cycle.
- Round-robin:
  - Stimulus: PORTS=3, all ports continuously send 1-flit packets.
  - Response: grant sequence 0,1,2,0,1,2. Every second cycle is an IDLE bubble.
- Packet atomicity under contention:
  - Stimulus: port 0 sends a 4-flit packet with in_valid low for 2 cycles mid-packet; port 2 requests throughout.
  - Response: all 4 port-0 flits leave contiguously in out_first/out_last order; in_ready[2]=0 until port 0's last flit has transferred; port 2 is granted next.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,1,0 during a 2-flit packet.
  - Response: each flit is held stable on out_* until its transfer; in_ready[grant] mirrors out_ready exactly.
- Reset mid-packet:
  - Stimulus: assert rst after flit 2 of a 5-flit packet.
  - Response: IDLE next cycle, out_valid=0; the next grant goes to port 0 if it requests.
- Stats (DII_ARB_STATS_EN):
  - Stimulus: 3 packets sent on port 1; separately, the port-0 counter is preloaded by sending 65536 packets.
  - Response: pkt_count[31:16]=3. The port-0 counter wraps to 0.

Source files
------------

// File: rtl/dii_packet_arbiter.sv
// Packet-atomic round-robin arbiter merging PORTS upstream DII channels onto one
// downstream channel. Define DII_ARB_STATS_EN to add per-port completed-packet counters.
module dii_packet_arbiter #(
  parameter int PORTS = 2,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PORTS*WIDTH-1:0]   in_data,
  input  logic [PORTS-1:0]         in_first,
  input  logic [PORTS-1:0]         in_last,
  input  logic [PORTS-1:0]         in_valid,
  output logic [PORTS-1:0]         in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef DII_ARB_STATS_EN
  ,
  output logic [PORTS*16-1:0]      pkt_count
`endif
);

  localparam int PW = $clog2(PORTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_grant;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_grant_next;
  logic [PW-1:0]   w_ptr_next;
  logic [PW-1:0]   w_winner;
  logic [PW-1:0]   w_win_hi;
  logic [PW-1:0]   w_win_lo;
  logic            w_found_hi;
  logic            w_found_lo;
  logic            w_any_req;
  logic            w_xfer;
  logic            w_pkt_done;
  logic [WIDTH-1:0] w_port_data [PORTS];

  if (PORTS < 2 || PORTS > 16) begin : g_bad_ports
    $error("dii_packet_arbiter: PORTS must be in 2..16");
  end

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_unpack
    assign w_port_data[gi] = in_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin search: ports above ptr first, then wrap to ports at or below ptr,
  // so the last winner always ends up with the lowest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default up front so no path infers a latch.
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_win_hi   = '0;
    w_win_lo   = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!w_found_hi && in_valid[i] && (i > int'(r_ptr))) begin
        w_found_hi = 1'b1;
        w_win_hi   = PW'(i);
      end
      if (!w_found_lo && in_valid[i] && (i <= int'(r_ptr))) begin
        w_found_lo = 1'b1;
        w_win_lo   = PW'(i);
      end
    end
    w_any_req = w_found_hi | w_found_lo;
    w_winner  = w_found_hi ? w_win_hi : w_win_lo;
  end

  // Zero-latency datapath: the granted port is wired straight through while BUSY.
  always_comb begin
    out_data  = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_valid = 1'b0;
    in_ready  = '0;
    if (r_state == ST_BUSY) begin
      out_data          = w_port_data[r_grant];
      out_first         = in_first[r_grant];
      out_last          = in_last[r_grant];
      out_valid         = in_valid[r_grant];
      in_ready[r_grant] = out_ready;
    end
  end

  assign w_xfer     = (r_state == ST_BUSY) && in_valid[r_grant] && out_ready;
  assign w_pkt_done = w_xfer && in_last[r_grant];

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_ptr_next   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_next = ST_BUSY;
          w_grant_next = w_winner;
          w_ptr_next   = w_winner;
        end
      end
      ST_BUSY: begin
        // Grant is held through mid-packet valid gaps; only the last flit releases it.
        if (w_pkt_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ptr resets to PORTS-1 so the first arbitration after reset favours port 0.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_ptr   <= PW'(PORTS - 1);
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_ptr   <= w_ptr_next;
    end
  end

`ifdef DII_ARB_STATS_EN
  logic [15:0] r_pkt_count [PORTS];

  always_ff @(posedge clk) begin
    // NOTE: the counter array is architectural state visible on a port, so it is reset explicitly.
    if (rst) begin
      for (int i = 0; i < PORTS; i++) begin
        r_pkt_count[i] <= '0;
      end
    end else if (w_pkt_done) begin
      r_pkt_count[r_grant] <= r_pkt_count[r_grant] + 16'd1;
    end
  end

  for (genvar gc = 0; gc < PORTS; gc++) begin : g_count_out
    assign pkt_count[gc*16 +: 16] = r_pkt_count[gc];
  end
`endif

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_valid_busy:   assert property (@(posedge clk) disable iff (rst) out_valid |-> (r_state == ST_BUSY));

endmodule
